// File: rtl/prince_mask_pkg.sv
// Shared constants and FSM state type for the masked PRINCE inverse S-box driver.
package prince_mask_pkg;

  localparam int NIBBLES = 16;
  localparam int STATE_W = 4 * NIBBLES;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam int R_W     = 108;
  localparam int RND_W   = 124;

  // Field offsets inside one randomness word: encoding mask, S-box randomness, neighbour seed.
  localparam int ENC_LO  = 0;
  localparam int R_LO    = 8;
  localparam int NB_LO   = 116;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/prince_nibble_masker.sv
// Splits one nibble into three Boolean shares using eight fresh random bits.
module prince_nibble_masker (
  input  logic [3:0] x,
  input  logic [7:0] r,
  output logic [3:0] sh1,
  output logic [3:0] sh2,
  output logic [3:0] sh3
);

  assign sh1 = r[3:0];
  assign sh2 = r[7:4];
  assign sh3 = x ^ r[3:0] ^ r[7:4];

endmodule

// File: rtl/prince_sbox_inv_serial_ctrl.sv
// Nibble-serial controller feeding a 3-share masked PRINCE inverse S-box (latency 1)
// and reassembling the unmasked 64-bit result.
module prince_sbox_inv_serial_ctrl
  import prince_mask_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [STATE_W-1:0]  in_state,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [RND_W-1:0]    rnd,
  output logic [3:0]          sb_in1,
  output logic [3:0]          sb_in2,
  output logic [3:0]          sb_in3,
  output logic [R_W-1:0]      sb_r,
  output logic [7:0]          sb_nb,
  input  logic [3:0]          sb_out1,
  input  logic [3:0]          sb_out2,
  input  logic [3:0]          sb_out3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [STATE_W-1:0]  out_state
);

  ctrl_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   pidx_q;
  logic               pending_q;
  logic [7:0]         nb_q;
  logic [STATE_W-1:0] in_q;
  logic [STATE_W-1:0] result_q;

  logic               issue;
  logic [3:0]         cur_nib;
  logic [3:0]         m1, m2, m3;

  assign issue   = (state_q == RUN) && rnd_valid;
  assign cur_nib = in_q[{cnt_q, 2'b00} +: 4];

  prince_nibble_masker u_masker (
    .x   (cur_nib),
    .r   (rnd[ENC_LO +: 8]),
    .sh1 (m1),
    .sh2 (m2),
    .sh3 (m3)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    rnd_ready = issue;
    sb_in1    = '0;
    sb_in2    = '0;
    sb_in3    = '0;
    sb_r      = '0;
    sb_nb     = '0;
    if (issue) begin
      sb_in1 = m1;
      sb_in2 = m2;
      sb_in3 = m3;
      sb_r   = rnd[R_LO +: R_W];
      sb_nb  = (cnt_q == '0) ? rnd[NB_LO +: 8] : nb_q;
    end
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (issue && (cnt_q == CNT_W'(NIBBLES - 1))) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        // Result is only exposed here, so a partially filled register never leaks out.
        out_valid = 1'b1;
        out_state = result_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pidx_q    <= '0;
      pending_q <= 1'b0;
      nb_q      <= '0;
      in_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= issue;
      if (state_q == IDLE && in_valid) begin
        in_q     <= in_state;
        cnt_q    <= '0;
        result_q <= '0;
      end
      if (issue) begin
        pidx_q <= cnt_q;
        cnt_q  <= cnt_q + 1'b1;
        nb_q   <= {m2, m1};
      end
      if (pending_q) begin
        result_q[{pidx_q, 2'b00} +: 4] <= sb_out1 ^ sb_out2 ^ sb_out3;
      end
    end
  end

endmodule

// File: tb/tb_prince_sbox_inv_serial_ctrl.sv
// Directed self-checking bench for prince_sbox_inv_serial_ctrl with a latency-1
// three-share inverse S-box model and an xorshift randomness source.
module tb_prince_sbox_inv_serial_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_state;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [123:0] rnd;
  logic [3:0]   sb_in1, sb_in2, sb_in3;
  logic [107:0] sb_r;
  logic [7:0]   sb_nb;
  logic [3:0]   sb_out1, sb_out2, sb_out3;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_state;

  int           comps = 0;
  int           fails = 0;
  logic [31:0]  prng;

  always #5 clk = ~clk;

  prince_sbox_inv_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd       (rnd),
    .sb_in1    (sb_in1),
    .sb_in2    (sb_in2),
    .sb_in3    (sb_in3),
    .sb_r      (sb_r),
    .sb_nb     (sb_nb),
    .sb_out1   (sb_out1),
    .sb_out2   (sb_out2),
    .sb_out3   (sb_out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  function automatic logic [3:0] inv_sbox(input logic [3:0] v);
    logic [63:0] tbl;
    tbl = 64'h1CE5046A98DF237B;
    return tbl[{v, 2'b00} +: 4];
  endfunction

  // Registered output shares re-randomised from sb_r; never combines masks of different issues.
  always_ff @(posedge clk) begin
    sb_out1 <= sb_r[3:0] ^ sb_r[11:8];
    sb_out2 <= sb_r[7:4];
    sb_out3 <= inv_sbox(sb_in1 ^ sb_in2 ^ sb_in3) ^ sb_r[3:0] ^ sb_r[11:8] ^ sb_r[7:4];
  end

  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic next_rnd();
    logic [127:0] t;
    for (int k = 0; k < 4; k++) begin
      prng = xs32(prng);
      t[32*k +: 32] = prng;
    end
    rnd = t[123:0];
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepts one state and drives the issue phase; returns the cycle index of first out_valid.
  task automatic run_op(input logic [63:0] st, input bit stall, output int cyc);
    int          issued;
    int          pulses;
    int          stalls;
    logic [7:0]  prev_nb;
    @(negedge clk);
    in_valid = 1'b1;
    in_state = st;
    #1 check("in_ready_idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    issued = 0;
    pulses = 0;
    stalls = 0;
    prev_nb = '0;
    while (issued < 16 && cyc < 120) begin
      prng = xs32(prng);
      rnd_valid = stall ? prng[7] : 1'b1;
      next_rnd();
      #1;
      if (rnd_ready) pulses++;
      if (rnd_valid) begin
        check("rnd_ready_issue", rnd_ready, 1'b1);
        check("share_xor", sb_in1 ^ sb_in2 ^ sb_in3, st[4*issued +: 4]);
        check("sb_nb", sb_nb, (issued == 0) ? rnd[123:116] : prev_nb);
        prev_nb = {sb_in2, sb_in1};
        issued++;
      end else begin
        check("rnd_ready_stall", rnd_ready, 1'b0);
        check("stall_zero", {sb_in1, sb_in2, sb_in3, sb_nb, sb_r}, '0);
        stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rnd_ready_pulses", pulses, 16);
    rnd_valid = 1'b1;
    next_rnd();
    #1;
    check("drain_no_issue", rnd_ready, 1'b0);
    check("drain_out_valid", out_valid, 1'b0);
    while (!out_valid && cyc < 140) begin
      @(negedge clk);
      cyc++;
      #1;
    end
    rnd_valid = 1'b0;
    check("out_valid_seen", out_valid, 1'b1);
    check("latency", cyc, 18 + stalls);
  endtask

  // Checks the result, optionally holds it with out_ready low while poking in_valid, then releases.
  task automatic finish_op(input logic [63:0] exp, input int hold);
    check("out_state", out_state, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_state = ~exp;
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_state", out_state, exp);
      check("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("back_idle_ready", in_ready, 1'b1);
    check("back_idle_valid", out_valid, 1'b0);
    check("back_idle_state", out_state, 64'h0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_state = '0;
    rnd_valid = 1'b0;
    rnd = '0;
    out_ready = 1'b0;
    prng = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_state", out_state, 64'h0);
    check("rst_rnd_ready", rnd_ready, 1'b0);
    rst_n = 1'b1;

    run_op(64'h0, 1'b0, cyc);
    check("latency_18", cyc, 18);
    finish_op(64'hBBBB_BBBB_BBBB_BBBB, 0);

    prng = 32'hDEAD_BEEF;
    run_op(64'hFEDC_BA98_7654_3210, 1'b0, cyc);
    finish_op(64'h1CE5_046A_98DF_237B, 0);
    prng = 32'h0BAD_F00D;
    run_op(64'hFEDC_BA98_7654_3210, 1'b0, cyc);
    finish_op(64'h1CE5_046A_98DF_237B, 0);
    prng = 32'h5A5A_1357;
    run_op(64'hFEDC_BA98_7654_3210, 1'b0, cyc);
    finish_op(64'h1CE5_046A_98DF_237B, 0);

    run_op(64'hFEDC_BA98_7654_3210, 1'b1, cyc);
    finish_op(64'h1CE5_046A_98DF_237B, 10);

    @(negedge clk);
    in_valid = 1'b1;
    in_state = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    in_valid = 1'b0;
    rnd_valid = 1'b1;
    repeat (7) begin
      next_rnd();
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_state", out_state, 64'h0);
    check("midrst_rnd_ready", rnd_ready, 1'b0);
    check("midrst_sb_in1", sb_in1, 4'h0);
    rst_n = 1'b1;
    rnd_valid = 1'b0;
    run_op(64'h0, 1'b0, cyc);
    finish_op(64'hBBBB_BBBB_BBBB_BBBB, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
